// File: rtl/window_level_meter.sv
// rtl/window_level_meter.sv - windowed peak / mean-magnitude / clip level meter
// Consumes one window of 2^LOG2_WIN signed samples and publishes its level statistics.
module window_level_meter #(
    parameter int                DATA_W      = 24,
    parameter int                LOG2_WIN    = 8,
    parameter logic [DATA_W-1:0] CLIP_THRESH = 24'h7FF000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] sample_data_i,
    input  logic              sample_valid_i,
    output logic              sample_ready_o,
    input  logic              buffer_ready_i,
    output logic [DATA_W-1:0] peak_o,
    output logic [DATA_W-1:0] mean_abs_o,
    output logic              clip_o,
    output logic              level_valid_o
);

    localparam int ACC_W = DATA_W + LOG2_WIN;

    localparam logic [DATA_W-1:0]   MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]   MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [LOG2_WIN-1:0] CNT_ONE  = LOG2_WIN'(1);
    localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ACC_W-1:0]    acc;
    logic [DATA_W-1:0]   peak;
    logic                clip;
    logic [LOG2_WIN-1:0] cnt;

    logic                accept;
    logic                last_accept;
    logic [DATA_W-1:0]   mag;
    logic [ACC_W-1:0]    acc_next;
    logic [DATA_W-1:0]   peak_next;
    logic                clip_next;

    // -2^(DATA_W-1) has no positive counterpart, so it saturates to the largest positive value
    always_comb begin
        mag = sample_data_i;
        if (sample_data_i[DATA_W-1]) begin
            if (sample_data_i == MOST_NEG) begin
                mag = MOST_POS;
            end else begin
                mag = '0 - sample_data_i;
            end
        end
    end

    assign accept      = sample_valid_i && sample_ready_o;
    assign last_accept = accept && (cnt == CNT_LAST);
    assign acc_next    = acc + {{LOG2_WIN{1'b0}}, mag};
    assign peak_next   = (mag > peak) ? mag : peak;
    assign clip_next   = clip || (mag >= CLIP_THRESH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (buffer_ready_i) state_next = ACCUM;
            ACCUM:   if (last_accept) state_next = PUBLISH;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sample_ready_o = (state == ACCUM);
        level_valid_o  = (state == PUBLISH);
    end

    // Published values are loaded on the final accept so they are already stable during the PUBLISH pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc        <= '0;
            peak       <= '0;
            clip       <= 1'b0;
            cnt        <= '0;
            peak_o     <= '0;
            mean_abs_o <= '0;
            clip_o     <= 1'b0;
        end else if (state == IDLE) begin
            acc  <= '0;
            peak <= '0;
            clip <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            acc  <= acc_next;
            peak <= peak_next;
            clip <= clip_next;
            cnt  <= cnt + CNT_ONE;
            if (last_accept) begin
                peak_o     <= peak_next;
                mean_abs_o <= acc_next[ACC_W-1:LOG2_WIN];
                clip_o     <= clip_next;
            end
        end
    end

endmodule
